// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit arbiter: line levels,
// FSM state encoding and the frame parity helper.
package serial_pkg;

    localparam int DATA_W_DEFAULT = 7;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_t;

    // Parity bit that makes the data+parity field carry an even count of ones.
    // Callers zero-extend their word to 32 bits.
    function automatic logic parity_of(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// Requester/line bundle of the serial transmit arbiter. The slave side is
// the arbiter itself; the master side is the set of producers plus the
// link consumer.
interface serial_tx_arbiter_if import serial_pkg::*; #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DATA_W_DEFAULT
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    serial_out;
    logic                    busy;
    logic [IDX_W-1:0]        grant_id;
    logic                    frame_done;

    modport master (
        output req_valid, req_data,
        input  req_ready, serial_out, busy, grant_id, frame_done
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, serial_out, busy, grant_id, frame_done
    );

endinterface

// File: rtl/serial_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping from the top index back to 0.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int               w_j;
    logic [IDX_W-1:0] w_pos;

    // Scan from the pointer upward and keep only the first hit.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        w_pos = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            w_pos = IDX_W'(w_j);
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter plus frame serialiser for a shared 1-bit link.
// Frame: start 0, DATA_W data bits LSB first, even parity, GAP stop cycles.
module serial_tx_arbiter import serial_pkg::*; #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int GAP    = 1
) (
    input  logic                clk,
    input  logic                rst,
    serial_tx_arbiter_if.slave  bus
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_EFF = (GAP < 1) ? 1 : GAP;
    localparam int CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W   = $clog2(GAP_EFF + 1);

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_EFF - 1);
    localparam logic [GAP_W-1:0] GAP_PENULT = GAP_W'(GAP_EFF - 2);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_REQ - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_grant;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [GAP_W-1:0]  r_gap;
    logic              r_serial;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_word;

    logic [N_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic              w_accept;
    logic [DATA_W-1:0] w_slice;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_slice  = bus.req_data[w_idx*DATA_W +: DATA_W];
    assign w_accept = (r_state == IDLE) && w_any;

    // Acceptance strobe is only offered from IDLE and never while in reset.
    assign bus.req_ready  = (r_state == IDLE && !rst) ? w_gnt : '0;
    assign bus.serial_out = r_serial;
    assign bus.busy       = r_busy;
    assign bus.grant_id   = r_grant;
    assign bus.frame_done = r_done;

    // Frame FSM; each transition also registers the line level for the state entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_bitcnt <= '0;
            r_gap    <= '0;
            r_serial <= LINE_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_idx;
                        r_ptr    <= (w_idx == IDX_LAST) ? '0 : w_idx + IDX_W'(1);
                        r_state  <= START;
                        r_serial <= START_BIT;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    r_state  <= DATA;
                    r_serial <= r_shift[0];
                    r_bitcnt <= '0;
                end
                DATA: begin
                    if (r_bitcnt == BIT_LAST) begin
                        r_state  <= PARITY;
                        r_serial <= parity_of(32'(r_word));
                    end else begin
                        r_serial <= r_shift[0];
                        r_bitcnt <= r_bitcnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    r_state  <= STOP;
                    r_serial <= LINE_IDLE;
                    r_gap    <= '0;
                    r_done   <= (GAP_EFF == 1);
                end
                STOP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_gap  <= r_gap + GAP_W'(1);
                        r_done <= (r_gap == GAP_PENULT);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_serial <= LINE_IDLE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    // Word capture at acceptance, then shift out one bit per START/DATA cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shift <= w_slice;
            r_word  <= w_slice;
        end else if (r_state == START || (r_state == DATA && r_bitcnt != BIT_LAST)) begin
            r_shift <= r_shift >> 1;
        end
    end

endmodule
